// File: rtl/input_scanner.sv
`default_nettype none
// ============================================================================
// Module   : input_scanner
// Brief    : Switch debouncer, quadrature steering flags and registered read mux.
// Revision : 1.0
// ============================================================================
module input_scanner #(
    parameter int NUM_SW    = 16,
    parameter int ADR_W     = 3,
    parameter int DEB_LEN   = 8,
    parameter int NUM_STEER = 2
) (
    input  logic                 Clk6,
    input  logic                 Reset_n,
    input  logic [NUM_SW-1:0]    Sw_n,
    input  logic [7:0]           DIP_Sw,
    input  logic [NUM_STEER-1:0] SteerA_n,
    input  logic [NUM_STEER-1:0] SteerB_n,
    input  logic [NUM_STEER-1:0] SteerReset_n,
    input  logic [ADR_W-1:0]     Adr,
    input  logic                 In_n,
    input  logic                 Steer_n,
    input  logic                 Opt_n,
    output logic [7:0]           DBus,
    output logic [NUM_SW-1:0]    Sw_Deb,
    output logic [NUM_STEER-1:0] SteerFlag,
    output logic [NUM_STEER-1:0] SteerDir
);

    localparam int c_addr_span = 1 << ADR_W;
    localparam int c_cnt_w     = $clog2(DEB_LEN + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEB_LEN - 1);

    logic [NUM_SW-1:0]    r_sw_s1;
    logic [NUM_SW-1:0]    r_sw_s2;
    logic [NUM_SW-1:0]    r_sw_deb;
    logic [c_cnt_w-1:0]   r_cnt [NUM_SW];
    logic [NUM_SW-1:0]    w_pressed;

    logic [NUM_STEER-1:0] r_a_s1;
    logic [NUM_STEER-1:0] r_a_s2;
    logic [NUM_STEER-1:0] r_a_prev;
    logic [NUM_STEER-1:0] r_b_s1;
    logic [NUM_STEER-1:0] r_b_s2;
    logic [NUM_STEER-1:0] r_flag;
    logic [NUM_STEER-1:0] r_dir;
    logic [NUM_STEER-1:0] w_a_fall;

    logic [c_addr_span-1:0] w_flag_pad;
    logic [c_addr_span-1:0] w_dir_pad;
    logic [c_addr_span-1:0] w_steer_ok;
    logic [7:0]             w_rd_data;
    logic [7:0]             r_dbus;

    assign w_pressed = ~r_sw_s2;
    assign w_a_fall  = r_a_prev & ~r_a_s2;

    // Synchronisers reset to the inactive level so refill cannot look like a press or an edge.
    always_ff @(posedge Clk6) begin
        if (!Reset_n) begin
            r_sw_s1  <= '1;
            r_sw_s2  <= '1;
            r_sw_deb <= '0;
            for (int i = 0; i < NUM_SW; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sw_s1 <= Sw_n;
            r_sw_s2 <= r_sw_s1;
            for (int i = 0; i < NUM_SW; i++) begin
                if (w_pressed[i] == r_sw_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == c_cnt_last) begin
                    r_sw_deb[i] <= ~r_sw_deb[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + c_cnt_w'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk6) begin
        if (!Reset_n) begin
            r_a_s1   <= '1;
            r_a_s2   <= '1;
            r_a_prev <= '1;
            r_b_s1   <= '1;
            r_b_s2   <= '1;
            r_flag   <= '0;
            r_dir    <= '0;
        end else begin
            r_a_s1   <= SteerA_n;
            r_a_s2   <= r_a_s1;
            r_a_prev <= r_a_s2;
            r_b_s1   <= SteerB_n;
            r_b_s2   <= r_b_s1;
            for (int c = 0; c < NUM_STEER; c++) begin
                if (w_a_fall[c]) begin
                    r_flag[c] <= 1'b1;
                    r_dir[c]  <= ~r_b_s2[c];
                end else if (!SteerReset_n[c]) begin
                    r_flag[c] <= 1'b0;
                    r_dir[c]  <= 1'b0;
                end
            end
        end
    end

    // Widen the steering state to the full address space so Adr indexes it directly.
    for (genvar i = 0; i < c_addr_span; i++) begin : g_pad
        if (i < NUM_STEER) begin : g_real
            assign w_flag_pad[i] = r_flag[i];
            assign w_dir_pad[i]  = r_dir[i];
            assign w_steer_ok[i] = 1'b1;
        end else begin : g_none
            assign w_flag_pad[i] = 1'b0;
            assign w_dir_pad[i]  = 1'b0;
            assign w_steer_ok[i] = 1'b0;
        end
    end

    always_comb begin
        w_rd_data = 8'hFF;
        if (!In_n) begin
            w_rd_data = {r_sw_deb[{1'b0, Adr}], 6'h3F, r_sw_deb[{1'b1, Adr}]};
        end else if (!Steer_n) begin
            if (w_steer_ok[Adr]) begin
                w_rd_data = {w_flag_pad[Adr], 6'h3F, w_dir_pad[Adr]};
            end
        end else if (!Opt_n) begin
            case (Adr[1:0])
                2'd0:    w_rd_data = {6'h3F, DIP_Sw[7], DIP_Sw[6]};
                2'd1:    w_rd_data = {6'h3F, DIP_Sw[5], DIP_Sw[4]};
                2'd2:    w_rd_data = {6'h3F, DIP_Sw[3], DIP_Sw[2]};
                default: w_rd_data = {6'h3F, DIP_Sw[1], DIP_Sw[0]};
            endcase
        end
    end

    always_ff @(posedge Clk6) begin
        if (!Reset_n) begin
            r_dbus <= 8'hFF;
        end else begin
            r_dbus <= w_rd_data;
        end
    end

    assign DBus      = r_dbus;
    assign Sw_Deb    = r_sw_deb;
    assign SteerFlag = r_flag;
    assign SteerDir  = r_dir;

endmodule
`default_nettype wire

// File: tb/tb_input_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_scanner
// Brief    : Directed self-checking bench for input_scanner.
// Revision : 1.0
// ============================================================================
module tb_input_scanner;

    logic        clk;
    logic        rst_n;
    logic [15:0] sw_n;
    logic [7:0]  dip;
    logic [1:0]  sa_n;
    logic [1:0]  sb_n;
    logic [1:0]  srst_n;
    logic [2:0]  adr;
    logic        in_n;
    logic        steer_n;
    logic        opt_n;
    logic [7:0]  dbus;
    logic [15:0] sw_deb;
    logic [1:0]  sflag;
    logic [1:0]  sdir;

    int checks;
    int failures;

    input_scanner #(
        .NUM_SW    (16),
        .ADR_W     (3),
        .DEB_LEN   (8),
        .NUM_STEER (2)
    ) dut (
        .Clk6         (clk),
        .Reset_n      (rst_n),
        .Sw_n         (sw_n),
        .DIP_Sw       (dip),
        .SteerA_n     (sa_n),
        .SteerB_n     (sb_n),
        .SteerReset_n (srst_n),
        .Adr          (adr),
        .In_n         (in_n),
        .Steer_n      (steer_n),
        .Opt_n        (opt_n),
        .DBus         (dbus),
        .Sw_Deb       (sw_deb),
        .SteerFlag    (sflag),
        .SteerDir     (sdir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(2);
        checks++; if (dbus !== 8'hFF) begin failures++; $display("FAIL reset_dbus got=%h exp=ff", dbus); end
        checks++; if (sw_deb !== 16'h0000) begin failures++; $display("FAIL reset_swdeb got=%h exp=0000", sw_deb); end
        checks++; if (sflag !== 2'b00 || sdir !== 2'b00) begin failures++; $display("FAIL reset_steer got=%b/%b exp=00/00", sflag, sdir); end
        rst_n = 1'b1;
        tick(3);
        checks++; if (sw_deb !== 16'h0000 || sflag !== 2'b00) begin failures++; $display("FAIL post_reset_quiet got=%h/%b exp=0000/00", sw_deb, sflag); end
    endtask

    task automatic test_debounce_latency;
        sw_n[3] = 1'b0;
        tick(9);
        checks++; if (sw_deb[3] !== 1'b0) begin failures++; $display("FAIL deb_early got=%b exp=0", sw_deb[3]); end
        tick(1);
        checks++; if (sw_deb[3] !== 1'b1) begin failures++; $display("FAIL deb_latency got=%b exp=1", sw_deb[3]); end
        in_n = 1'b0; adr = 3'd3;
        tick(1);
        checks++; if (dbus !== 8'hFE) begin failures++; $display("FAIL in_read_lo got=%h exp=fe", dbus); end
        in_n = 1'b1;
        tick(1);
        checks++; if (dbus !== 8'hFF) begin failures++; $display("FAIL no_select got=%h exp=ff", dbus); end
        sw_n[3] = 1'b1;
        sw_n[11] = 1'b0;
        tick(10);
        checks++; if (sw_deb[3] !== 1'b0 || sw_deb[11] !== 1'b1) begin failures++; $display("FAIL deb_swap got=%b%b exp=01", sw_deb[3], sw_deb[11]); end
        in_n = 1'b0;
        tick(1);
        checks++; if (dbus !== 8'h7F) begin failures++; $display("FAIL in_read_hi got=%h exp=7f", dbus); end
        in_n = 1'b1;
        sw_n[11] = 1'b1;
        tick(10);
        checks++; if (sw_deb !== 16'h0000) begin failures++; $display("FAIL deb_release got=%h exp=0000", sw_deb); end
    endtask

    task automatic test_glitch;
        logic seen;
        seen = 1'b0;
        sw_n[5] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick(1);
            if (sw_deb[5]) seen = 1'b1;
        end
        sw_n[5] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (sw_deb[5]) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL short_pulse got=%b exp=0", seen); end
        seen = 1'b0;
        sw_n[5] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (sw_deb[5]) seen = 1'b1;
        end
        sw_n[5] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (sw_deb[5]) seen = 1'b1;
        end
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL full_pulse got=%b exp=1", seen); end
        checks++; if (sw_deb[5] !== 1'b0) begin failures++; $display("FAIL pulse_settle got=%b exp=0", sw_deb[5]); end
    endtask

    task automatic test_steer;
        sb_n[1] = 1'b0;
        tick(3);
        sa_n[1] = 1'b0;
        tick(2);
        checks++; if (sflag[1] !== 1'b0) begin failures++; $display("FAIL steer_early got=%b exp=0", sflag[1]); end
        tick(1);
        checks++; if (sflag[1] !== 1'b1 || sdir[1] !== 1'b1) begin failures++; $display("FAIL steer_edge got=%b%b exp=11", sflag[1], sdir[1]); end
        steer_n = 1'b0; adr = 3'd1;
        tick(1);
        checks++; if (dbus !== 8'hFF) begin failures++; $display("FAIL steer_read1 got=%h exp=ff", dbus); end
        adr = 3'd0;
        tick(1);
        checks++; if (dbus !== 8'h7E) begin failures++; $display("FAIL steer_read0 got=%h exp=7e", dbus); end
        adr = 3'd5;
        tick(1);
        checks++; if (dbus !== 8'hFF) begin failures++; $display("FAIL steer_read5 got=%h exp=ff", dbus); end
        steer_n = 1'b1;
        sa_n[1] = 1'b1; sb_n[1] = 1'b1;
        tick(4);
        checks++; if (sflag[1] !== 1'b1 || sdir[1] !== 1'b1) begin failures++; $display("FAIL steer_hold got=%b%b exp=11", sflag[1], sdir[1]); end
    endtask

    task automatic test_steer_reset;
        sb_n[0] = 1'b0;
        tick(3);
        sa_n[0] = 1'b0;
        tick(3);
        checks++; if (sflag[0] !== 1'b1 || sdir[0] !== 1'b1) begin failures++; $display("FAIL sr_setup got=%b%b exp=11", sflag[0], sdir[0]); end
        sa_n[0] = 1'b1;
        tick(3);
        srst_n[0] = 1'b0;
        tick(1);
        srst_n[0] = 1'b1;
        checks++; if (sflag[0] !== 1'b0 || sdir[0] !== 1'b0) begin failures++; $display("FAIL sr_clear got=%b%b exp=00", sflag[0], sdir[0]); end
        sb_n[0] = 1'b1;
        tick(3);
        sa_n[0] = 1'b0;
        tick(2);
        srst_n[0] = 1'b0;
        tick(1);
        srst_n[0] = 1'b1;
        checks++; if (sflag[0] !== 1'b1 || sdir[0] !== 1'b0) begin failures++; $display("FAIL sr_edge_wins got=%b%b exp=10", sflag[0], sdir[0]); end
        checks++; if (sflag[1] !== 1'b1) begin failures++; $display("FAIL sr_other_chan got=%b exp=1", sflag[1]); end
        sa_n[0] = 1'b1;
        tick(3);
    endtask

    task automatic test_opt;
        logic [7:0] exp_tbl [4];
        exp_tbl[0] = 8'hFE; exp_tbl[1] = 8'hFE; exp_tbl[2] = 8'hFD; exp_tbl[3] = 8'hFD;
        opt_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            adr = 3'(k);
            tick(1);
            checks++; if (dbus !== exp_tbl[k]) begin failures++; $display("FAIL opt_read%0d got=%h exp=%h", k, dbus, exp_tbl[k]); end
        end
        steer_n = 1'b0; adr = 3'd1;
        tick(1);
        checks++; if (dbus !== 8'hFF) begin failures++; $display("FAIL prio_steer_opt got=%h exp=ff", dbus); end
        in_n = 1'b0;
        tick(1);
        checks++; if (dbus !== 8'h7E) begin failures++; $display("FAIL prio_in got=%h exp=7e", dbus); end
        in_n = 1'b1; steer_n = 1'b1; opt_n = 1'b1;
        tick(1);
    endtask

    task automatic test_reset_mid;
        sw_n[0] = 1'b0;
        tick(7);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        checks++; if (sw_deb[0] !== 1'b0 || sflag !== 2'b00) begin failures++; $display("FAIL mid_reset got=%b/%b exp=0/00", sw_deb[0], sflag); end
        tick(9);
        checks++; if (sw_deb[0] !== 1'b0) begin failures++; $display("FAIL restart_early got=%b exp=0", sw_deb[0]); end
        tick(1);
        checks++; if (sw_deb[0] !== 1'b1) begin failures++; $display("FAIL restart_latency got=%b exp=1", sw_deb[0]); end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; sw_n = '1; dip = 8'hA5;
        sa_n = '1; sb_n = '1; srst_n = '1;
        adr = '0; in_n = 1'b1; steer_n = 1'b1; opt_n = 1'b1;
        test_reset;
        test_debounce_latency;
        test_glitch;
        test_steer;
        test_steer_reset;
        test_opt;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/input_scanner.md
INPUT_SCANNER -- requirements
Module: input_scanner

Interface
REQ-001 Parameter NUM_SW, default 16: number of active-low switch inputs; SHALL equal 2*2^ADR_W.
REQ-002 Parameter ADR_W, default 3: read-address width.
REQ-003 Parameter DEB_LEN, default 8: consecutive-sample debounce length in clocks; legal range 1..255.
REQ-004 Parameter NUM_STEER, default 2: number of quadrature steering channels; legal range 1..2^ADR_W.
REQ-005 Clk6  in  1  sole clock; one clock; reset is synchronous and active-low.
REQ-006 Reset_n  in  1  synchronous active-low reset, sampled on Clk6 rising edge.
REQ-007 Sw_n  in  NUM_SW  asynchronous switch inputs (coin, start, gears, gas, test, slam...); low = pressed.
REQ-008 DIP_Sw  in  8  static option switches; not synchronised.
REQ-009 SteerA_n, SteerB_n  in  NUM_STEER each  asynchronous quadrature encoder phases, active low.
REQ-010 SteerReset_n  in  NUM_STEER  per-channel steering-flag clear, active low, synchronous.
REQ-011 Adr  in  ADR_W  read address.
REQ-012 In_n, Steer_n, Opt_n  in  1 each  active-low read selects.
REQ-013 DBus  out  8  registered read data.
REQ-014 Sw_Deb  out  NUM_SW  debounced switch states, active high (1 = pressed).
REQ-015 SteerFlag, SteerDir  out  NUM_STEER each  steering movement flag and direction.

Function
REQ-016 Each bit of Sw_n, SteerA_n and SteerB_n SHALL pass through a 2-flop synchroniser before any other use.
REQ-017 Each switch SHALL own a counter of ceil(log2(DEB_LEN+1)) bits; the counter clears on any cycle where the synchronised level equals the current Sw_Deb state.
REQ-018 The counter increments on each cycle where the synchronised level differs; on the DEB_LEN-th consecutive differing cycle Sw_Deb toggles on that edge and the counter clears.
REQ-019 A differing run shorter than DEB_LEN cycles SHALL leave Sw_Deb unchanged; the counter SHALL never wrap.
REQ-020 Latency from a stable Sw_n change to Sw_Deb change SHALL be exactly 2+DEB_LEN clocks.
REQ-021 Steering channel c SHALL detect a falling edge of synchronised SteerA_n[c] (1 in previous cycle, 0 now).
REQ-022 On that edge SteerFlag[c] <= 1 and SteerDir[c] <= (synchronised SteerB_n[c] == 0).
REQ-023 SteerReset_n[c] low SHALL clear SteerFlag[c] and SteerDir[c] to 0; if an A edge occurs in the same cycle, the edge wins (flag set, dir loaded).
REQ-024 Read priority: In_n, then Steer_n, then Opt_n; DBus SHALL be registered, reflecting Adr and the selects of the previous edge (1-cycle latency).
REQ-025 In_n low: DBus <= {Sw_Deb[Adr], 6'b111111, Sw_Deb[Adr + 2^ADR_W]}.
REQ-026 Steer_n low, Adr < NUM_STEER: DBus <= {SteerFlag[Adr], 6'b111111, SteerDir[Adr]}; Adr >= NUM_STEER: DBus <= 8'hFF.
REQ-027 Opt_n low: DBus <= {6'b111111, DIP_Sw[7-2k], DIP_Sw[6-2k]}, with k = Adr[1:0].
REQ-028 No select low: DBus <= 8'hFF.
REQ-029 Reads SHALL have no side effects; reading never clears SteerFlag.

Reset
REQ-030 While Reset_n is low at an edge: synchronisers <= 1 (inactive), counters <= 0, Sw_Deb <= 0, SteerFlag <= 0, SteerDir <= 0, DBus <= 8'hFF.
REQ-031 Reset SHALL take priority over every other update, including a mid-debounce count or a coincident A edge.
REQ-032 After Reset_n rises, no Sw_Deb change and no A edge SHALL be reported for the first 2 clocks; synchroniser refill from 1 cannot fake a falling edge.

Verification
REQ-033 Defaults; Sw_n[3] driven low and held -> Sw_Deb[3] = 1 exactly 10 clocks later; In_n low with Adr = 3 -> DBus = 8'hFE one clock later.
REQ-034 Sw_n[5] low-pulse of 7 clocks, then high -> Sw_Deb[5] stays 0 throughout; an 8-clock pulse -> Sw_Deb[5] = 1 for at least one cycle.
REQ-035 SteerB_n[1] = 0, then SteerA_n[1] falls -> SteerFlag[1] = 1 and SteerDir[1] = 1 three clocks later; Steer_n low with Adr = 1 -> DBus = 8'hFF; Adr = 5 -> DBus = 8'hFF.
REQ-036 SteerReset_n[0] low in the same cycle as a synchronised A edge with B_n = 1 -> SteerFlag[0] = 1 and SteerDir[0] = 0; SteerReset_n[0] low alone -> both 0.
REQ-037 DIP_Sw = 8'hA5, Opt_n low, Adr = 0..3 -> DBus = FE, FE, FD, FD; In_n and Opt_n low together -> switch data returned.
REQ-038 Reset_n low for 1 clock while Sw_n[0] is 5 clocks into a debounce -> counter = 0 and Sw_Deb = 0; full 2+DEB_LEN latency restarts after reset.
